// File: rtl/dff.sv
// dff: N-bit clocked register with an optional chain of DEPTH identical
// stages, giving a fixed DEPTH-cycle delay from I to O. Reset is synchronous
// and active-high on the port named reset_n (the name is historical; the
// register resets while reset_n = 1). O comes straight from the last stage's
// flops, so there is no combinational path from I or reset_n to O.
module dff #(
  parameter int              N           = 16,
  parameter int              DEPTH       = 1,
  parameter logic [N-1:0]    RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] I,
  output logic [N-1:0] O
);

  // Reject meaningless configurations while the design is elaborated.
  generate
    if (N < 1) begin : g_bad_width
      $error("dff: N must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
      $error("dff: DEPTH must be at least 1");
    end
  endgenerate

  // Stage 0 is nearest the input; stage DEPTH-1 drives O.
  logic [N-1:0] stage_q [DEPTH];
  logic [N-1:0] stage_d [DEPTH];

  // Next value of each stage when not in reset: shift one place toward O.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    stage_d[0] = I;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Stage registers: reset wins over data on the same edge and flushes every stage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (reset_n) begin
        stage_q[k] <= RESET_VALUE;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign O = stage_q[DEPTH-1];

endmodule

// File: tb/tb_dff.sv
// Bench for dff: a default instance (N=16, DEPTH=1, reset value 0) and a
// DEPTH=3, N=8, reset value A5 instance run side by side. The reference model
// keeps the per-edge history of (reset, input) and derives O from it: if any
// of the last DEPTH edges was a reset, O is the reset value, otherwise O is
// the input applied DEPTH-1 edges before the latest one.
module tb_dff;

  localparam int          D16  = 1;
  localparam int          D8   = 3;
  localparam logic [15:0] RV16 = 16'h0000;
  localparam logic [7:0]  RV8  = 8'hA5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] i16;
  logic [7:0]  i8;
  logic [15:0] o16;
  logic [7:0]  o8;

  always #5 clk = ~clk;

  dff #(.N(16)) u_dff16 (
    .clk     (clk),
    .reset_n (reset_n),
    .I       (i16),
    .O       (o16)
  );

  dff #(.N(8), .DEPTH(D8), .RESET_VALUE(RV8)) u_dff8 (
    .clk     (clk),
    .reset_n (reset_n),
    .I       (i8),
    .O       (o8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  bit          h16_rst[$];
  logic [15:0] h16_val[$];
  bit          h8_rst[$];
  logic [7:0]  h8_val[$];
  bit          seen_reset = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp16();
    int sz;
    sz = h16_rst.size();
    for (int i = 0; i < D16 && i < sz; i++) begin
      if (h16_rst[sz-1-i]) return RV16;
    end
    return h16_val[sz-D16];
  endfunction

  function automatic logic [7:0] exp8();
    int sz;
    sz = h8_rst.size();
    for (int i = 0; i < D8 && i < sz; i++) begin
      if (h8_rst[sz-1-i]) return RV8;
    end
    return h8_val[sz-D8];
  endfunction

  // Record what the edge just taken saw, then compare both outputs.
  task automatic record_and_check(input string tag, input bit r, input logic [15:0] a, input logic [7:0] b);
    h16_rst.push_back(r);
    h16_val.push_back(a);
    h8_rst.push_back(r);
    h8_val.push_back(b);
    if (r) seen_reset = 1'b1;
    if (seen_reset) begin
      check_eq({tag, "_o16"}, o16, exp16());
      check_eq({tag, "_o8"}, {8'h00, o8}, {8'h00, exp8()});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input string tag, input bit r, input logic [15:0] a, input logic [7:0] b);
    reset_n = r;
    i16     = a;
    i8      = b;
    @(posedge clk);
    #1;
    record_and_check(tag, r, a, b);
  endtask

  // Same as step, but wiggle I and reset_n between edges and confirm O holds.
  task automatic step_glitch(input string tag, input bit r, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] hold16;
    logic [7:0]  hold8;
    reset_n = r;
    i16     = a;
    i8      = b;
    hold16  = o16;
    hold8   = o8;
    #1;
    reset_n = ~r;
    i16     = ~a;
    i8      = ~b;
    #1;
    check_eq({tag, "_hold16"}, o16, hold16);
    check_eq({tag, "_hold8"}, {8'h00, o8}, {8'h00, hold8});
    #1;
    reset_n = r;
    i16     = a;
    i8      = b;
    @(posedge clk);
    #1;
    record_and_check(tag, r, a, b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b1;
    i16     = '0;
    i8      = '0;
    @(negedge clk);

    // Reset held with changing data: outputs stay at reset value.
    step("rst0", 1'b1, 16'h0001, 8'h11);
    step("rst1", 1'b1, 16'h0002, 8'h22);
    step("rst2", 1'b1, 16'h0004, 8'h33);

    // Pass-through after release.
    step("pt0", 1'b0, 16'h0010, 8'h01);
    step("pt1", 1'b0, 16'h0020, 8'h02);
    step("pt2", 1'b0, 16'h0040, 8'h03);

    // One-edge reset mid-stream, then live data again.
    step("midrst", 1'b1, 16'h0080, 8'h04);
    step("post0", 1'b0, 16'h0100, 8'h05);
    step("post1", 1'b0, 16'h0200, 8'h06);
    step("post2", 1'b0, 16'h0400, 8'h07);

    // Between-edge wiggles on inputs and reset.
    for (int k = 0; k < 6; k++) begin
      step_glitch("glitch", (k == 3), 16'($urandom), 8'($urandom));
    end

    // Walking ones through every bit.
    for (int k = 0; k < 16; k++) begin
      step("walk", 1'b0, 16'h0001 << k, 8'h01 << (k % 8));
    end

    // Random traffic with occasional reset pulses.
    for (int k = 0; k < 300; k++) begin
      step("rand", ($urandom_range(0, 15) == 0), 16'($urandom), 8'($urandom));
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dff.md
# dff

Parameterised N-bit clocked register (default 16 bits) with a synchronous, active-high reset. It is the generic data-holding/pipeline-delay element used on datapath buses. The input word is captured on each rising clock edge and presented on the output. An optional depth parameter chains identical stages to give a fixed multi-cycle delay.

## Interface

Parameters:
- N, default 16: data width in bits, ≥ 1.
- DEPTH, default 1: number of cascaded register stages, ≥ 1; sets the latency in cycles.
- RESET_VALUE, default {N{1'b0}}: value loaded into every stage on reset.

Ports (positional order clk, reset_n, I, O):
- clk, input, 1: single clock; all state updates on its rising edge only.
- reset_n, input, 1: one clock; reset is synchronous and active-high. Port name kept per codebase convention; reset asserts when reset_n = 1.
- I, input, N: data word to capture.
- O, output, N: registered data, driven directly from the last stage's flops.

## Operation

- Stage 0 captures I; stage k captures stage k-1; O = stage DEPTH-1.
- On a rising clk edge with reset_n = 1: every stage loads RESET_VALUE; I is ignored for that edge.
- On a rising clk edge with reset_n = 0: all stages shift as above.
- No enable: every non-reset edge loads new data.
- All N bits are handled independently; no arithmetic, sign or width conversion.
- Reset dominates data on the same edge.
- DEPTH < 1 or N < 1 is a configuration error and must be rejected at elaboration.

## Timing

- Latency I → O: exactly DEPTH rising edges. Default: 1 edge, value visible after that edge.
- Reset:
  - Takes effect on the first rising edge at which reset_n = 1.
  - O reads RESET_VALUE from that edge on and stays there while reset_n stays high.
  - Reset is not asynchronous: asserting or deasserting reset_n between edges has no effect until the next edge.
- Reset release:
  - First edge with reset_n = 0 captures current I into stage 0.
  - For DEPTH = 1, O shows that I immediately after the edge.
  - For DEPTH > 1, O shows RESET_VALUE for DEPTH-1 further edges, then live data.
- Reset mid-stream: data in flight in all stages is discarded on the reset edge; it never appears on O.
- Power-up: O is undefined until the first reset edge. Benches must apply reset first.
- O must be glitch-free between edges, with no combinational path from I or reset_n to O.

## Test plan

- Reset on: reset_n = 1, I = 16'h0001, then 16'h0002, then 16'h0004 over three edges -> O = 16'h0000 after each edge.
- Pass-through, DEPTH = 1:
  - Stimulus: reset_n = 0, I = 16'h0010, 16'h0020, 16'h0040, 16'h0080 on successive edges.
  - Required: O equals each value one edge after it was applied.
- Single-cycle reset pulse mid-stream:
  - Stimulus: O = 16'h0040; then reset_n = 1 for one edge with I = 16'h0080; then reset_n = 0 with I = 16'h0100.
  - Required: O = 16'h0000 after the reset edge, then 16'h0100 after the next edge.
- Between-edge changes:
  - Stimulus: toggle I and reset_n between edges, restoring them before the edge.
  - Required: O never changes except at rising edges.
- DEPTH = 3, N = 8, RESET_VALUE = 8'hA5:
  - Stimulus: reset for one edge, then I = 8'h01, 8'h02, 8'h03.
  - Required: O = A5, A5, A5, then 01 on the 3rd post-release edge, 02 and 03 on the following edges.
- Walking ones, N = 16, reset deasserted: drive I = 1 << k for k = 0..15 -> O = 1 << k one edge later, every bit exercised.
